// File: rtl/counter_sequencer.sv
// counter_sequencer: prescaled up-counter sequencer with a valid/ready config handshake,
// start/stop strobes, and per-increment tick / terminal-count done reporting.
module counter_sequencer #(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   cfg_limit,
    input  logic [PRESC_W-1:0] cfg_prescale,
    input  logic               cfg_mode,
    input  logic               start,
    input  logic               stop,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               tick,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

    state_t             state;
    logic [PRESC_W-1:0] pre;
    logic [PRESC_W-1:0] presc_r;
    logic [WIDTH-1:0]   limit_r;
    logic               mode_r;
    logic               cfg_fire;

    assign busy      = (state == RUN);
    assign cfg_ready = (state != RUN);
    assign cfg_fire  = cfg_valid && cfg_ready;
    // stop suppresses a same-cycle tick, so no increment or done can slip through
    assign tick      = (state == RUN) && (pre == presc_r) && !stop;
    assign done      = tick && (count == limit_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            pre     <= '0;
            limit_r <= '0;
            presc_r <= '0;
            mode_r  <= 1'b0;
        end else if (cfg_fire) begin
            // config is only accepted outside RUN and always wins over start
            limit_r <= cfg_limit;
            presc_r <= cfg_prescale;
            mode_r  <= cfg_mode;
            count   <= '0;
            state   <= ARMED;
        end else begin
            case (state)
                ARMED, DONE: if (start) begin
                    count <= '0;
                    pre   <= '0;
                    state <= RUN;
                end
                RUN: if (stop) begin
                    pre   <= '0;
                    state <= ARMED;
                end else begin
                    pre <= (pre == presc_r) ? '0 : pre + 1'b1;
                    if (done) begin
                        if (mode_r) count <= '0;
                        else        state <= DONE;
                    end else if (tick) begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: table-driven per-cycle vectors plus a hand-written reset-abort sequence.
module tb_counter_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_mode = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] cfg_limit = '0;
    logic [3:0] cfg_prescale = '0;
    logic       cfg_ready, busy, tick, done;
    logic [3:0] count;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        logic       cv;
        logic [3:0] lim;
        logic [3:0] p;
        logic       m;
        logic       st;
        logic       sp;
        logic [3:0] c;
        logic       b;
        logic       t;
        logic       d;
        logic       r;
    } vec_t;

    vec_t vecs[$];

    counter_sequencer #(.WIDTH(4), .PRESC_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_limit(cfg_limit), .cfg_prescale(cfg_prescale), .cfg_mode(cfg_mode),
        .start(start), .stop(stop), .count(count), .busy(busy), .tick(tick), .done(done)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic cv, input logic [3:0] lim, input logic [3:0] p,
                                input logic m, input logic st, input logic sp,
                                input logic [3:0] c, input logic b, input logic t,
                                input logic d, input logic r);
        vec_t x;
        x.cv = cv; x.lim = lim; x.p = p; x.m = m; x.st = st; x.sp = sp;
        x.c = c; x.b = b; x.t = t; x.d = d; x.r = r;
        vecs.push_back(x);
    endfunction

    // packed as {count, busy, tick, done, cfg_ready}
    function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {count,busy,tick,done,ready}=%h want %h", name, act, exp);
        end
    endfunction

    initial begin
        // one-shot limit=3 prescale=0
        add(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 4'(i), 1, 1, i == 3, 0);
        add(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1);
        // auto-reload limit=2 prescale=2
        add(1, 2, 2, 1, 0, 0, 3, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 18; i++)
            add(0, 0, 0, 0, 0, 0, 4'(((i - 1) / 3) % 3), 1, i % 3 == 0, i % 9 == 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        // stop colliding with a tick at count=4
        add(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 9; i++) add(0, 0, 0, 0, 0, 0, 4'((i - 1) / 2), 1, i % 2 == 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        // config and start together: config wins, then run to 7
        add(1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 0, 0, 4'(i), 1, 1, i == 7, 0);
        add(0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1);
        // limit=0 auto-reload prescale=3
        add(1, 0, 3, 1, 0, 0, 7, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 12; i++) add(0, 0, 0, 0, 0, 0, 0, 1, i % 4 == 0, i % 4 == 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        // full-range one-shot; stray start and cfg_valid in RUN must be ignored
        add(1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) add(i == 6, 3, 1, 1, i == 5, 0, 4'(i), 1, 1, i == 15, 0);
        add(0, 0, 0, 0, 0, 0, 15, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 15, 0, 0, 0, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", {count, busy, tick, done, cfg_ready}, 8'h01);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            cfg_valid = vecs[k].cv; cfg_limit = vecs[k].lim; cfg_prescale = vecs[k].p;
            cfg_mode = vecs[k].m; start = vecs[k].st; stop = vecs[k].sp;
            @(negedge clk);
            check($sformatf("vec%0d", k), {count, busy, tick, done, cfg_ready},
                  {vecs[k].c, vecs[k].b, vecs[k].t, vecs[k].d, vecs[k].r});
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;

        // reset asserted mid-RUN at count=5 aborts with no done
        cfg_valid = 1'b1; cfg_limit = 4'd9; cfg_prescale = 4'd0; cfg_mode = 1'b0;
        @(posedge clk);
        #1 cfg_valid = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_reset_run", {count, busy, tick, done, cfg_ready}, {4'd5, 4'b1100});
        #1 rst_n = 1'b0;
        #1 check("async_reset", {count, busy, tick, done, cfg_ready}, 8'h01);
        @(posedge clk);
        #1 rst_n = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("idle_start_ignored%0d", i), {count, busy, tick, done, cfg_ready}, 8'h01);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Programmable controller that configures and sequences a WIDTH-bit up-counter. It accepts a terminal count, prescale divisor and reload mode over a valid/ready config handshake. Software-style start/stop strobes then run the counter, and the block reports per-increment ticks and terminal-count done pulses. It replaces free-running ripple counting wherever firmware needs a deterministic, fully synchronous, restartable count.

Parameters:
WIDTH, 4, counter and limit width in bits
PRESC_W, 4, prescale register width in bits

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
cfg_valid  input  1  config word present
cfg_ready  output  1  config accepted when cfg_valid && cfg_ready at the rising edge
cfg_limit  input  WIDTH  terminal count value
cfg_prescale  input  PRESC_W  one count per (cfg_prescale+1) RUN cycles
cfg_mode  input  1  0 = one-shot, 1 = auto-reload
start  input  1  begin counting from 0 (single-cycle strobe)
stop  input  1  halt counting (single-cycle strobe)
count  output  WIDTH  current count, registered
busy  output  1  high while in RUN
tick  output  1  high in each cycle where count advances
done  output  1  high in the cycle where the terminal tick occurs

Behaviour:
- Reset (async, rst_n=0): state=IDLE; count, prescaler, limit_r, presc_r and mode_r all 0. Outputs while in reset: busy=0, tick=0, done=0, cfg_ready=1. Reset asserted mid-RUN aborts immediately, with no done pulse.
- Registered state: state, count, pre (PRESC_W-bit prescaler), limit_r, presc_r, mode_r.
- tick = (state==RUN) && (pre==presc_r) && !stop.
- done = tick && (count==limit_r).
- busy = (state==RUN). cfg_ready = (state!=RUN).
- IDLE:
  - Config handshake: latch limit_r, presc_r and mode_r; count<=0; go to ARMED.
  - start is ignored.
- ARMED:
  - Config handshake: re-latch the config; count<=0; stay in ARMED.
  - Otherwise, start: count<=0, pre<=0, go to RUN.
  - If a config handshake and start occur in the same cycle, the config wins and start is dropped.
- RUN:
  - Prescaler: pre increments each cycle. When pre==presc_r, pre<=0.
  - On tick with count!=limit_r: count<=count+1.
  - On done, mode_r=1: count<=0, stay in RUN.
  - On done, mode_r=0: count holds limit_r, go to DONE.
  - stop: go to ARMED. count holds its value; pre<=0. stop has priority over a same-cycle tick: no increment, no tick, no done.
  - start while in RUN is ignored. cfg_valid is not accepted while in RUN.
- DONE:
  - count holds limit_r.
  - start: count<=0, pre<=0, go to RUN.
  - Config handshake: re-latch config, count<=0, go to ARMED.
  - Config beats start when both occur in the same cycle.
- Timing:
  - Latency: start sampled at edge E puts the block in RUN from E+1.
  - The first tick occurs presc_r cycles after entering RUN. With presc_r=0, the first tick is in the first RUN cycle.
  - One-shot run length from entering RUN to the done cycle inclusive: (limit_r+1)*(presc_r+1) cycles.
- Boundaries:
  - limit_r=0: every tick is terminal and count stays 0. Auto-reload then gives done every presc_r+1 cycles.
  - limit_r = 2^WIDTH-1: count reaches all-ones, then reloads to 0 or holds; it never wraps through the adder.
  - Arithmetic is unsigned, and the count+1 result is truncated to WIDTH bits. Truncation is never exercised, because the count==limit_r check precedes any increment.

Test Plan:
- Reset during RUN at count=5 -> next cycle count=0, busy=0, cfg_ready=1; a subsequent start without config is ignored (state stays IDLE).
- Config limit=3, prescale=0, mode=0, then start -> ticks in 4 consecutive cycles; count goes 1,2,3; done high with count=3 on the 4th RUN cycle; busy drops next cycle; count holds 3.
- Config limit=2, prescale=2, mode=1, run 18 cycles -> tick every 3rd cycle; count sequence 0,1,2,0,1,2; done every 9 cycles; busy stays 1.
- In RUN with limit=9, prescale=1, assert stop in the same cycle as a tick at count=4 -> no tick, count stays 4, state ARMED; next start -> count restarts at 0.
- In ARMED, assert cfg_valid (limit=7) and start together -> config accepted, no RUN. Start next cycle runs to 7.
- limit=0, prescale=3, mode=1 -> count always 0; done pulse every 4 cycles. Then limit=15, prescale=0, mode=0 -> done at count=15 after 16 RUN cycles; count never wraps.
